// File: rtl/tinynpu_pkg.sv
// tinynpu shared constants: command opcodes, controller trace states,
// sequencer FSM encodings and the command legality rule.
package tinynpu_pkg;

    localparam logic [1:0] OP_LDX = 2'd0;
    localparam logic [1:0] OP_LDW = 2'd1;
    localparam logic [1:0] OP_RUN = 2'd2;
    localparam logic [1:0] OP_FIN = 2'd3;

    localparam logic [1:0] NPU_LD0 = 2'd0;
    localparam logic [1:0] NPU_MAC = 2'd1;
    localparam logic [1:0] NPU_LD1 = 2'd2;
    localparam logic [1:0] NPU_OUT = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    function automatic logic op_legal(logic [1:0] op, logic [1:0] ns);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LDX:  ok = (ns == NPU_LD0);
            OP_LDW:  ok = (ns == NPU_LD0) || (ns == NPU_LD1);
            OP_RUN:  ok = (ns == NPU_LD0) || (ns == NPU_LD1);
            default: ok = (ns == NPU_LD1);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tinynpu_cmd_seq_if.sv
// Host-facing command and data-beat handshake bundle
// for the tinynpu command sequencer.
interface tinynpu_cmd_seq_if #(
    parameter int SIZE = 4,
    parameter int DW   = 8
);
    localparam int SW = $clog2(SIZE);

    logic          cmd_val;
    logic          cmd_rdy;
    logic [1:0]    cmd_op;
    logic [SW-1:0] cmd_sel;
    logic [SW:0]   cmd_len;
    logic          dat_val;
    logic          dat_rdy;
    logic [DW-1:0] dat;

    modport master (
        output cmd_val, cmd_op, cmd_sel, cmd_len, dat_val, dat,
        input  cmd_rdy, dat_rdy
    );

    modport slave (
        input  cmd_val, cmd_op, cmd_sel, cmd_len, dat_val, dat,
        output cmd_rdy, dat_rdy
    );

endinterface

// File: rtl/tinynpu_cmd_seq.sv
// Host command sequencer pacing LDX/LDW/RUN/FIN against the NPU trace state.
// Optional watchdog: define TINYNPU_SEQ_TIMEOUT_EN.
module tinynpu_cmd_seq
    import tinynpu_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    tinynpu_cmd_seq_if.slave        host,
    input  logic [3:0]              npu_state,
    output logic                    x_load_val,
    output logic                    w_load_val,
    output logic [$clog2(SIZE)-1:0] w_load_sel,
    output logic [DW-1:0]           load_data,
    output logic                    mac_val,
    output logic                    out_val,
    output logic                    done,
    output logic                    err
);
    localparam int SW = $clog2(SIZE);
    localparam int LW = SW + 1;
    localparam int unused_tmo = TIMEOUT;

    logic [2:0]    state_q;
    logic [1:0]    op_q;
    logic [SW-1:0] sel_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] cnt_q;
    logic          mac_q;
    logic          out_q;
    logic          done_q;
    logic          err_q;

    logic [1:0] ns;
    logic       npu_unused;
    logic       acc;
    logic       is_load;
    logic       ok;
    logic       beat;
    logic       last;
    logic       tmo;

    assign ns         = npu_state[1:0];
    assign npu_unused = ^npu_state[3:2];
    assign acc        = host.cmd_val & host.cmd_rdy;
    assign is_load    = (host.cmd_op == OP_LDX) | (host.cmd_op == OP_LDW);
    assign ok         = op_legal(host.cmd_op, ns)
                      & ~(is_load & (host.cmd_len > LW'(SIZE)));
    assign beat       = (state_q == ST_LOAD) & host.dat_val;
    assign last       = beat & ((cnt_q + LW'(1)) == len_q);

`ifdef TINYNPU_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    prev_q;
    logic [TW-1:0] wd_q;
    logic [TW-1:0] wd_c;
    logic          waiting;

    assign waiting = (state_q == ST_RUN) | (state_q == ST_WAIT)
                   | (state_q == ST_FIN);
    assign wd_c    = (state_q != prev_q) ? TW'(1) : wd_q + TW'(1);
    assign tmo     = waiting & (wd_c == TW'(TIMEOUT));

    // Count consecutive cycles in a waiting state, restarting on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= ST_IDLE;
            wd_q   <= '0;
        end else begin
            prev_q <= state_q;
            wd_q   <= waiting ? wd_c : '0;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Command FSM: accept/check, stream beats, pace RUN and FIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            sel_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            mac_q   <= 1'b0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        op_q  <= host.cmd_op;
                        sel_q <= host.cmd_sel;
                        len_q <= host.cmd_len;
                        cnt_q <= '0;
                        if (!ok) begin
                            err_q <= 1'b1;
                        end else if (is_load) begin
                            if (host.cmd_len == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end else if (host.cmd_op == OP_RUN) begin
                            mac_q   <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            out_q   <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_LOAD: begin
                    if (last) begin
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (beat) begin
                        cnt_q <= cnt_q + LW'(1);
                    end
                end
                ST_RUN: begin
                    if (ns == NPU_MAC) begin
                        mac_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ns == NPU_LD1) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_FIN: begin
                    if (ns == NPU_OUT) begin
                        done_q  <= 1'b1;
                        out_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (tmo) begin
                err_q   <= 1'b1;
                mac_q   <= 1'b0;
                out_q   <= 1'b0;
                done_q  <= 1'b0;
                state_q <= ST_IDLE;
            end
        end
    end

    assign host.cmd_rdy = (state_q == ST_IDLE);
    assign host.dat_rdy = (state_q == ST_LOAD);
    assign x_load_val   = beat & (op_q == OP_LDX);
    assign w_load_val   = beat & (op_q == OP_LDW);
    assign load_data    = beat ? host.dat : '0;
    assign w_load_sel   = sel_q;
    assign mac_val      = mac_q;
    assign out_val      = out_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_tinynpu_cmd_seq.sv
// Randomized self-checking bench for tinynpu_cmd_seq against a
// transaction-level model of the command rules.
module tb_tinynpu_cmd_seq;
    import tinynpu_pkg::*;

    localparam int SIZE = 4;
    localparam int DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tinynpu_cmd_seq_if #(.SIZE(SIZE), .DW(DW)) bus ();

    logic [3:0]    npu_state;
    logic          x_load_val;
    logic          w_load_val;
    logic [1:0]    w_load_sel;
    logic [DW-1:0] load_data;
    logic          mac_val;
    logic          out_val;
    logic          done;
    logic          err;

    tinynpu_cmd_seq #(.SIZE(SIZE), .DW(DW), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (bus.slave),
        .npu_state  (npu_state),
        .x_load_val (x_load_val),
        .w_load_val (w_load_val),
        .w_load_sel (w_load_sel),
        .load_data  (load_data),
        .mac_val    (mac_val),
        .out_val    (out_val),
        .done       (done),
        .err        (err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_x = 0, n_w = 0, n_mac = 0, n_out = 0, n_done = 0;
    int exp_sel = 0;
    bit m_err = 1'b0;
    logic [DW-1:0] obs_q[$];
    logic [DW-1:0] exp_q[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe DUT outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (x_load_val) begin
                n_x++;
                obs_q.push_back(load_data);
            end
            if (w_load_val) begin
                n_w++;
                obs_q.push_back(load_data);
                chk("w_sel", 32'(w_load_sel), 32'(exp_sel));
            end
            if (mac_val) n_mac++;
            if (out_val) n_out++;
            if (done) n_done++;
            if (mac_val | out_val) chk("mac_out_excl", 32'(mac_val & out_val), 0);
        end
    end

    function automatic bit model_legal(logic [1:0] op, logic [1:0] st, int len);
        bit ok;
        if (op == OP_LDX) ok = (st == NPU_LD0);
        else if (op == OP_FIN) ok = (st == NPU_LD1);
        else ok = (st == NPU_LD0) || (st == NPU_LD1);
        if ((op == OP_LDX || op == OP_LDW) && len > SIZE) ok = 1'b0;
        return ok;
    endfunction

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(logic [1:0] op, int sel, int len);
        int t = 0;
        bus.cmd_val = 1'b1;
        bus.cmd_op  = op;
        bus.cmd_sel = 2'(sel);
        bus.cmd_len = 3'(len);
        while (!bus.cmd_rdy && t < 100) begin
            cyc(1);
            t++;
        end
        if (t >= 100) chk("cmd_rdy_wait", 0, 1);
        cyc(1);
        bus.cmd_val = 1'b0;
    endtask

    task automatic beats(int n, bit gaps, bit seqd);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if (gaps && $urandom_range(0, 1) == 1) cyc($urandom_range(1, 2));
            chk("busy_cmd_rdy", 32'(bus.cmd_rdy), 0);
            bus.dat     = seqd ? DW'(i + 1) : DW'($urandom);
            bus.dat_val = 1'b1;
            exp_q.push_back(bus.dat);
            while (!bus.dat_rdy && t < 100) begin
                cyc(1);
                t++;
            end
            if (t >= 100) chk("dat_rdy_wait", 0, 1);
            cyc(1);
            bus.dat_val = 1'b0;
        end
    endtask

    task automatic wait_done(int base);
        int t = 0;
        while (n_done == base && t < 60) begin
            cyc(1);
            t++;
        end
        cyc(2);
    endtask

    task automatic do_cmd(logic [1:0] op, logic [1:0] st, int sel, int len,
                          bit gaps, bit seqd, int k1, int k2);
        int bx, bw, bd, bm, bo;
        int ka, kb;
        bit lg;
        bx = n_x; bw = n_w; bd = n_done; bm = n_mac; bo = n_out;
        obs_q.delete();
        exp_q.delete();
        exp_sel   = sel;
        ka        = (k1 == 0) ? $urandom_range(1, 8) : k1;
        kb        = (k2 == 0) ? $urandom_range(1, 8) : k2;
        npu_state = {2'b00, st};
        lg        = model_legal(op, st, len);
        issue(op, sel, len);
        if (!lg) begin
            m_err       = 1'b1;
            bus.dat     = 8'hA5;
            bus.dat_val = 1'b1;
            cyc(2);
            bus.dat_val = 1'b0;
            cyc(1);
            chk("illegal_cmd_rdy", 32'(bus.cmd_rdy), 1);
        end else if (op == OP_LDX || op == OP_LDW) begin
            if (len > 0) beats(len, gaps, seqd);
            wait_done(bd);
        end else if (op == OP_RUN) begin
            cyc(ka - 1);
            npu_state = {2'b00, NPU_MAC};
            cyc(kb);
            npu_state = {2'b00, NPU_LD1};
            wait_done(bd);
        end else begin
            cyc(ka - 1);
            npu_state = {2'b00, NPU_OUT};
            wait_done(bd);
        end
        chk("x_pulses", 32'(n_x - bx), (lg && op == OP_LDX) ? 32'(len) : 0);
        chk("w_pulses", 32'(n_w - bw), (lg && op == OP_LDW) ? 32'(len) : 0);
        chk("done_pulses", 32'(n_done - bd), lg ? 1 : 0);
        chk("mac_cycles", 32'(n_mac - bm), (lg && op == OP_RUN) ? 32'(ka) : 0);
        chk("out_cycles", 32'(n_out - bo), (lg && op == OP_FIN) ? 32'(ka) : 0);
        chk("err", 32'(err), 32'(m_err));
        chk("data_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk("load_data", 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        logic [1:0] rop;
        logic [1:0] rst_st;
        bus.cmd_val = 1'b0;
        bus.cmd_op  = '0;
        bus.cmd_sel = '0;
        bus.cmd_len = '0;
        bus.dat_val = 1'b0;
        bus.dat     = '0;
        npu_state   = {2'b00, NPU_LD0};
        #1 rst = 1'b0;
        cyc(2);
        chk("rst_outs", 32'({x_load_val, w_load_val, mac_val, out_val, done, err}), 0);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 1);
        chk("rst_dat_rdy", 32'(bus.dat_rdy), 0);
        rst = 1'b1;
        cyc(2);

        do_cmd(OP_LDX, NPU_LD0, 0, 4, 1'b0, 1'b1, 0, 0);
        do_cmd(OP_LDW, NPU_LD0, 2, 3, 1'b1, 1'b0, 0, 0);
        do_cmd(OP_RUN, NPU_LD0, 0, 0, 1'b0, 1'b0, 5, 8);
        do_cmd(OP_LDW, NPU_LD1, 3, 0, 1'b0, 1'b0, 0, 0);
        do_cmd(OP_LDX, NPU_LD1, 0, 2, 1'b0, 1'b0, 0, 0);
        do_cmd(OP_FIN, NPU_LD0, 0, 0, 1'b0, 1'b0, 0, 0);
        do_cmd(OP_LDX, NPU_LD0, 0, 5, 1'b0, 1'b0, 0, 0);
        do_cmd(OP_LDW, NPU_LD1, 1, 4, 1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            rop    = 2'($urandom_range(0, 3));
            rst_st = 2'($urandom_range(0, 2));
            if (rop == OP_FIN && rst_st == NPU_LD1) rst_st = NPU_LD0;
            do_cmd(rop, rst_st, $urandom_range(0, 3), $urandom_range(0, 5),
                   1'b1, 1'b0, 0, 0);
        end

`ifdef TINYNPU_SEQ_TIMEOUT_EN
        begin
            int bm, bd;
            bm = n_mac;
            bd = n_done;
            npu_state = {2'b00, NPU_LD0};
            issue(OP_RUN, 0, 0);
            cyc(80);
            chk("tmo_mac_cycles", 32'(n_mac - bm), 64);
            chk("tmo_done", 32'(n_done - bd), 0);
            chk("tmo_err", 32'(err), 1);
            chk("tmo_mac_low", 32'(mac_val), 0);
            m_err = 1'b1;
        end
`endif

        npu_state = {2'b00, NPU_LD0};
        issue(OP_LDX, 0, 4);
        beats(2, 1'b0, 1'b1);
        bus.dat     = 8'h5A;
        bus.dat_val = 1'b1;
        #3 rst = 1'b0;
        #1;
        chk("abort_outs", 32'({x_load_val, w_load_val, bus.dat_rdy,
                               mac_val, out_val, done, err, load_data}), 0);
        chk("abort_cmd_rdy", 32'(bus.cmd_rdy), 1);
        bus.dat_val = 1'b0;
        cyc(2);
        rst   = 1'b1;
        m_err = 1'b0;
        cyc(1);
        do_cmd(OP_LDX, NPU_LD0, 0, 1, 1'b0, 1'b0, 0, 0);

        do_cmd(OP_FIN, NPU_LD1, 0, 0, 1'b0, 1'b0, 2, 0);
        do_cmd(OP_LDW, NPU_OUT, 1, 2, 1'b0, 1'b0, 0, 0);
        do_cmd(OP_RUN, NPU_OUT, 0, 0, 1'b0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
